serial_subtractor: RTL

- Multi-cycle bit-serial subtractor computing a − b.
- Built from a full-subtractor cell chain that processes STEP bits per clock, LSB first, with the borrow held in a register between cycles.
- Sits beside the ALU as a low-area subtract/compare unit for the pipeline's multi-cycle path.
- Uses a start/done handshake and produces difference, borrow, zero and signed-overflow flags.

---
 rtl/serial_subtractor_pkg.sv | 24 ++
 rtl/serial_subtractor_full_subtractor.sv | 20 ++
 rtl/serial_subtractor.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_pkg
// Description : Shared constants, state encoding and helpers for the
//               bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Controller state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter width for n iterations; never narrower than one bit so that
  // the single-iteration build still has a legal counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : One-bit full subtractor cell, x - y - b_in.
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = x ^ y ^ b_in;
  // Borrow when y exceeds x, or when they are equal and a borrow comes in
  assign b_out = (~x & y) | (~(x ^ y) & b_in);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Multi-cycle bit-serial subtractor (a - b), STEP bits per
//               clock LSB first, with start/done handshake and
//               borrow / zero / signed-overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             overflow
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic [STEP-1:0]  w_d;
  logic [STEP:0]    w_bchain;
  logic [WIDTH-1:0] w_diff_next;
  logic             w_last;

  assign w_last = (r_cnt == C_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; start is only honoured from IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Borrow chain across the STEP cells, seeded from the registered borrow
  assign w_bchain[0] = r_borrow;

  generate
    for (genvar i = 0; i < STEP; i++) begin : g_cell
      full_subtractor u_fs (
        .x     (r_a[i]),
        .y     (r_b[i]),
        .b_in  (w_bchain[i]),
        .d     (w_d[i]),
        .b_out (w_bchain[i+1])
      );
    end
  endgenerate

  // Result assembly: new bits enter at the MSB end. With a single
  // iteration the cell outputs are the whole result and no partial
  // register is needed.
  generate
    if (STEP == WIDTH) begin : g_single
      assign w_diff_next = w_d;
    end else begin : g_multi
      logic [WIDTH-STEP-1:0] r_diff_sh;

      // Partial result register, only advanced while running
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                   r_diff_sh <= '0;
        else if (r_state == ST_RUN) r_diff_sh <= w_diff_next[WIDTH-1:STEP];
      end

      assign w_diff_next = {w_d, r_diff_sh};
    end
  endgenerate

  // Operand capture, serial shifting and completion of the visible result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
      r_borrow   <= 1'b0;
      r_cnt      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        ST_RUN: begin
          r_a      <= r_a >> STEP;
          r_b      <= r_b >> STEP;
          r_borrow <= w_bchain[STEP];
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            diff       <= w_diff_next;
            borrow_out <= w_bchain[STEP];
            zero       <= (w_diff_next == '0);
            overflow   <= (r_a_msb != r_b_msb) && (w_diff_next[WIDTH-1] != r_a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
